// File: rtl/matmul_sequencer.sv
// 2x2 matrix multiply sequencer: captures two 2x2 matrices of 2-bit
// unsigned operands from switches, then streams the eight product beats
// to an external multiply-accumulate unit and writes back the four sums.
module matmul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] switches,
  input  logic        load,
  input  logic        start,
  output logic        load_done,
  output logic        mac_valid,
  input  logic        mac_ready,
  output logic [1:0]  mac_a,
  output logic [1:0]  mac_b,
  output logic        mac_clr,
  input  logic [4:0]  mac_acc,
  output logic        res_we,
  output logic [1:0]  res_addr,
  output logic [4:0]  res_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADED = 3'd1,
    ISSUE  = 3'd2,
    WB     = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  a_reg, a_next;
  logic [7:0]  b_reg, b_next;
  logic [1:0]  e_reg, e_next;   // result element index (row-major)
  logic        k_reg, k_next;   // inner-product term index

  // Unpack the MSB-first operand registers into row-major element views.
  logic [1:0] a_elem [4];
  logic [1:0] b_elem [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      assign a_elem[gi] = a_reg[7-2*gi -: 2];
      assign b_elem[gi] = b_reg[7-2*gi -: 2];
    end
  endgenerate

  // State and operand registers; reset forces IDLE without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= 8'd0;
      b_reg     <= 8'd0;
      e_reg     <= 2'd0;
      k_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      e_reg     <= e_next;
      k_reg     <= k_next;
    end
  end

  // Next-state logic and state-decoded outputs; load beats start wherever both are honoured.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    e_next     = e_reg;
    k_next     = k_reg;
    load_done  = 1'b0;
    mac_valid  = 1'b0;
    mac_a      = 2'd0;
    mac_b      = 2'd0;
    mac_clr    = 1'b0;
    res_we     = 1'b0;
    res_addr   = 2'd0;
    res_data   = 5'd0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load) begin
          a_next     = switches[15:8];
          b_next     = switches[7:0];
          state_next = LOADED;
        end
      end

      LOADED: begin
        load_done = 1'b1;
        if (load) begin
          a_next = switches[15:8];
          b_next = switches[7:0];
        end else if (start) begin
          e_next     = 2'd0;
          k_next     = 1'b0;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        busy      = 1'b1;
        mac_valid = 1'b1;
        // c[i][j] term k uses a[i][k] and b[k][j], with i = e>>1, j = e&1.
        mac_a     = a_elem[{e_reg[1], k_reg}];
        mac_b     = b_elem[{k_reg, e_reg[0]}];
        mac_clr   = ~k_reg;
        if (mac_ready) begin
          if (!k_reg) begin
            k_next = 1'b1;
          end else begin
            state_next = WB;
          end
        end
      end

      WB: begin
        busy     = 1'b1;
        res_we   = 1'b1;
        res_addr = e_reg;
        res_data = mac_acc;
        if (e_reg == 2'd3) begin
          state_next = DONE;
        end else begin
          e_next     = e_reg + 2'd1;
          k_next     = 1'b0;
          state_next = ISSUE;
        end
      end

      DONE: begin
        done = 1'b1;
        if (load) begin
          a_next     = switches[15:8];
          b_next     = switches[7:0];
          state_next = LOADED;
        end else if (start) begin
          e_next     = 2'd0;
          k_next     = 1'b0;
          state_next = ISSUE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a behavioural MAC unit and a
// matrix-product reference model check every beat, write-back and latency.
module tb_matmul_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] switches;
  logic        load;
  logic        start;
  logic        load_done;
  logic        mac_valid;
  logic        mac_ready;
  logic [1:0]  mac_a;
  logic [1:0]  mac_b;
  logic        mac_clr;
  logic [4:0]  mac_acc;
  logic        res_we;
  logic [1:0]  res_addr;
  logic [4:0]  res_data;
  logic        busy;
  logic        done;

  int compared;
  int mismatched;

  localparam logic [15:0] CASE1 = 16'b11100110_01110010;
  localparam logic [15:0] CASE2 = 16'b01011011_11011110;

  matmul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .switches(switches), .load(load), .start(start),
    .load_done(load_done), .mac_valid(mac_valid), .mac_ready(mac_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: registered accumulator updated on the handshake edge.
  always @(posedge clk or negedge rst_n) begin
    logic [4:0] prod;
    if (!rst_n) begin
      mac_acc <= 5'd0;
    end else if (mac_valid && mac_ready) begin
      prod = {3'b000, mac_a} * {3'b000, mac_b};
      mac_acc <= mac_clr ? prod : mac_acc + prod;
    end
  end

  // A[i][k] from the switch word, row-major MSB-first.
  function automatic int fa(input logic [15:0] sw, input int i, input int k);
    logic [31:0] w;
    w = {16'd0, sw};
    return int'((w >> (14 - 2 * (2 * i + k))) & 32'd3);
  endfunction

  function automatic int fb(input logic [15:0] sw, input int k, input int j);
    logic [31:0] w;
    w = {16'd0, sw};
    return int'((w >> (6 - 2 * (2 * k + j))) & 32'd3);
  endfunction

  function automatic logic [4:0] ref_c(input logic [15:0] sw, input int e);
    int i, j, s;
    i = e / 2;
    j = e % 2;
    s = fa(sw, i, 0) * fb(sw, 0, j) + fa(sw, i, 1) * fb(sw, 1, j);
    return s[4:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_load(input logic [15:0] sw);
    switches = sw;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one computation from just after the start edge (edge 0) to done,
  // checking every beat, every write and the total latency.
  task automatic compute(input logic [15:0] sw, input int stall_pct,
                         input bit inject_load, input string tag);
    int n, stalls, ptr, writes, e, k;
    bit fin;
    logic [4:0] exp_beat, got_beat;
    n = 0; stalls = 0; ptr = 0; writes = 0; fin = 1'b0;
    while (!fin && n < 300) begin
      mac_ready = ($urandom_range(99) >= stall_pct);
      if (inject_load && (n == 1 || n == 6)) begin
        load = 1'b1;
        switches = ~sw;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        fin = 1'b1;
        compared++;
        if (n !== 12 + stalls || busy !== 1'b0) begin
          mismatched++;
          $display("FAIL %s latency: got %0d cycles busy=%b, need %0d busy=0", tag, n, busy, 12 + stalls);
        end
      end else begin
        compared++;
        if (busy !== 1'b1 || load_done !== 1'b0) begin
          mismatched++;
          $display("FAIL %s busy: cycle %0d got busy=%b load_done=%b, need 1/0", tag, n, busy, load_done);
        end
        if (mac_valid) begin
          compared++;
          if (ptr >= 8) begin
            mismatched++;
            $display("FAIL %s beat_count: got beat %0d, need at most 8", tag, ptr + 1);
          end else begin
            e = ptr / 2;
            k = ptr % 2;
            exp_beat = {2'(fa(sw, e / 2, k)), 2'(fb(sw, k, e % 2)), (k == 0)};
            got_beat = {mac_a, mac_b, mac_clr};
            if (got_beat !== exp_beat) begin
              mismatched++;
              $display("FAIL %s beat%0d: got a=%0d b=%0d clr=%b, need a=%0d b=%0d clr=%b",
                       tag, ptr, got_beat[4:3], got_beat[2:1], got_beat[0],
                       exp_beat[4:3], exp_beat[2:1], exp_beat[0]);
            end
          end
          if (mac_ready) ptr++;
          else stalls++;
        end
        if (res_we) begin
          compared++;
          if (writes >= 4 || res_addr !== writes[1:0] || res_data !== ref_c(sw, writes)) begin
            mismatched++;
            $display("FAIL %s write%0d: got addr=%0d data=%0d, need addr=%0d data=%0d",
                     tag, writes, res_addr, res_data, writes, ref_c(sw, writes));
          end else begin
            $display("%s write addr=%0d data=%0d", tag, res_addr, res_data);
          end
          writes++;
        end
      end
      tick();
      if (!fin) n++;
    end
    load = 1'b0;
    mac_ready = 1'b1;
    compared++;
    if (!fin || writes !== 4 || ptr !== 8) begin
      mismatched++;
      $display("FAIL %s totals: got done=%b writes=%0d beats=%0d, need 1/4/8", tag, fin, writes, ptr);
    end
    $display("%s sw=%h stalls=%0d latency=%0d", tag, sw, stalls, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    compared++;
    if ({load_done, mac_valid, mac_a, mac_b, mac_clr, res_we, res_addr, res_data, busy, done} !== 17'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b, need all 0",
               {load_done, mac_valid, mac_a, mac_b, mac_clr, res_we, res_addr, res_data, busy, done});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("test_reset complete");
  endtask

  task automatic run_full(input logic [15:0] sw, input int stall_pct, input string tag);
    pulse_load(sw);
    compared++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s load_done: got %b busy=%b, need 1/0", tag, load_done, busy);
    end
    pulse_start();
    compute(sw, stall_pct, 1'b0, tag);
  endtask

  task automatic test_case1();
    run_full(CASE1, 0, "case1");
  endtask

  task automatic test_case2();
    do_reset();
    run_full(CASE2, 0, "case2");
  endtask

  task automatic test_max();
    run_full(16'hFFFF, 0, "max");
  endtask

  task automatic test_stall();
    run_full(CASE1, 40, "stall");
  endtask

  task automatic test_ignore_load();
    pulse_load(CASE2);
    pulse_start();
    compute(CASE2, 20, 1'b1, "ign_load");
  endtask

  task automatic test_back_to_back();
    // From DONE, start alone reruns on the held operands.
    pulse_start();
    compute(CASE2, 0, 1'b0, "rerun");
    // From DONE, load recaptures and returns to LOADED.
    pulse_load(CASE1);
    compared++;
    if (load_done !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL done_load: got load_done=%b done=%b, need 1/0", load_done, done);
    end
    pulse_start();
    compute(CASE1, 0, 1'b0, "reload");
  endtask

  task automatic test_edges();
    do_reset();
    pulse_start();
    repeat (2) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || mac_valid !== 1'b0 || load_done !== 1'b0) begin
        mismatched++;
        $display("FAIL idle_start: got busy=%b valid=%b load_done=%b, need 0", busy, mac_valid, load_done);
      end
      tick();
    end
    pulse_load(CASE1);
    switches = CASE2;
    load = 1'b1;
    start = 1'b1;
    tick();
    load = 1'b0;
    start = 1'b0;
    @(negedge clk);
    compared++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL load_start: got load_done=%b busy=%b, need 1/0", load_done, busy);
    end
    tick();
    pulse_start();
    compute(CASE2, 0, 1'b0, "edge_recap");
  endtask

  task automatic test_random();
    logic [15:0] sw;
    for (int r = 0; r < 6; r++) begin
      sw = 16'($urandom);
      run_full(sw, 25, "random");
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    bit hit;
    pulse_load(CASE1);
    pulse_start();
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 20) begin
      @(negedge clk);
      if (res_we && res_addr == 2'd1) hit = 1'b1;
      else tick();
      guard++;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL mid_wb_reach: got no write to addr 1 within 20 cycles, need one");
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({load_done, mac_valid, mac_a, mac_b, mac_clr, res_we, res_addr, res_data, busy, done} !== 17'd0) begin
      mismatched++;
      $display("FAIL async_reset: got %b, need all 0",
               {load_done, mac_valid, mac_a, mac_b, mac_clr, res_we, res_addr, res_data, busy, done});
    end
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (res_we !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold: got res_we=%b busy=%b, need 0", res_we, busy);
      end
    end
    rst_n = 1'b1;
    tick();
    pulse_start();
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || res_we !== 1'b0 || load_done !== 1'b0) begin
        mismatched++;
        $display("FAIL post_reset_start: got busy=%b res_we=%b load_done=%b, need 0", busy, res_we, load_done);
      end
      tick();
    end
    $display("test_reset_mid complete");
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst_n = 1'b0;
    switches = 16'd0;
    load = 1'b0;
    start = 1'b0;
    mac_ready = 1'b1;
    test_reset();
    test_case1();
    test_case2();
    test_max();
    test_stall();
    test_ignore_load();
    test_back_to_back();
    test_edges();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-003 SHALL have port: switches  in  16  operands; [15:8] = A = {a00,a01,a10,a11}, [7:0] = B = {b00,b01,b10,b11}; 2-bit unsigned each, MSB-first.
REQ-004 SHALL have port: load  in  1  single-cycle debounced pulse; capture switches.
REQ-005 SHALL have port: start  in  1  single-cycle debounced pulse; begin multiply.
REQ-006 SHALL have port: load_done  out  1  operands captured, not yet started.
REQ-007 SHALL have port: mac_valid  out  1  MAC beat request.
REQ-008 SHALL have port: mac_ready  in  1  MAC accepts beat.
REQ-009 SHALL have port: mac_a, mac_b  out  2 each  beat operands.
REQ-010 SHALL have port: mac_clr  out  1  beat starts a new sum (accumulator loads the product instead of adding it).
REQ-011 SHALL have port: mac_acc  in  5  MAC accumulator, registered; updates on the handshake edge.
REQ-012 SHALL have port: res_we, res_addr[1:0], res_data[4:0]  out  result write port.
REQ-013 SHALL have port: busy  out  1  computation in progress.
REQ-014 SHALL have port: done  out  1  all four results written.

Function
REQ-015 SHALL implement states IDLE, LOADED, ISSUE, WB, DONE.
REQ-016 IDLE: load -> capture switches into operand regs, go LOADED; start ignored.
REQ-017 LOADED: load -> recapture, stay LOADED; start (without load) -> ISSUE with e=0, k=0; load and start in the same cycle -> load wins, start dropped.
REQ-018 ISSUE: mac_valid=1, mac_a=a[e>>1][k], mac_b=b[k][e&1], mac_clr=(k==0); a handshake occurs when mac_valid and mac_ready are both high.
REQ-019 ISSUE: on a handshake with k=0, set k=1 and stay in ISSUE; on a handshake with k=1, go to WB.
REQ-020 ISSUE: mac_a, mac_b and mac_clr SHALL hold stable while mac_ready is low.
REQ-021 WB: single cycle; res_we=1, res_addr=e, res_data=mac_acc; if e<3, then e+1, k=0 -> ISSUE; if e=3 -> DONE.
REQ-022 Element order: addr 0=c00, 1=c01, 2=c10, 3=c11; cij = ai0*b0j + ai1*b1j, unsigned; max 18 fits 5 bits with no truncation.
REQ-023 DONE: done=1 held; start -> rerun with the held operands (-> ISSUE, e=0, done drops); load -> recapture, -> LOADED, done drops.
REQ-024 load and start SHALL be ignored in ISSUE and WB.
REQ-025 busy=1 exactly in ISSUE and WB; load_done=1 exactly in LOADED.
REQ-026 mac_valid, res_we and mac_clr SHALL be 0 outside ISSUE/WB as applicable; res_addr and res_data SHALL be 0 when res_we=0.
REQ-027 Latency with mac_ready tied high: start accepted at edge 0; 3 cycles per element; done=1 after edge 12; exactly 4 res_we pulses.
REQ-028 mac_ready stall: each low cycle extends latency by exactly one cycle; no beat is dropped or duplicated.

Reset
REQ-029 rst_n low SHALL force IDLE immediately (asynchronously), without waiting for a clock edge.
REQ-030 Reset values: operands=0, e=k=0; all outputs 0.
REQ-031 Reset asserted mid-computation SHALL abort with no further res_we; after release, the block requires a new load.
REQ-032 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Verification
REQ-033 Case 1: switches=16'b11100110_01110010, load, start -> writes addr0..3 = 3, 13, 1, 7; done=1 at cycle 12.
REQ-034 Case 2: rst_n pulse, then switches=16'b01011011_11011110, load, start -> writes 6, 3, 15, 8.
REQ-035 Max operands: switches=16'hFFFF -> all four results = 18; mac_clr high only on k=0 beats.
REQ-036 Random mac_ready stalls on case 1 -> same results; operands stable during stall; latency = 12 + number of stall cycles.
REQ-037 Edge events: start in IDLE -> no activity; load and start together in LOADED -> stays LOADED; load during ISSUE -> ignored; rst_n low during WB of e=1 -> no further writes, state IDLE, outputs 0.
